// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then one cycle of sign fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // op encoding: bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  state_t               r_state;
  state_t               w_state_next;
  logic [1:0]           r_op;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_opd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last_iter;
  logic                 w_is_div;
  logic                 w_is_signed;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];

  // Operand magnitudes: signed ops take the two's-complement absolute value.
  always_comb begin
    w_mag_a = src_a;
    w_mag_b = src_b;
    if (!op[0] && src_a[WIDTH-1]) w_mag_a = -src_a;
    if (!op[0] && src_b[WIDTH-1]) w_mag_b = -src_b;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next-state logic
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)       w_state_next = RUN;
      RUN:     if (w_last_iter) w_state_next = FIX;
      FIX:                      w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    busy = (r_state == RUN) || (r_state == FIX);
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath. r_acc holds {partial product, multiplier} when
  // multiplying and {remainder, dividend/quotient} when dividing.
  // ---------------------------------------------------------------------------
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff  = w_shift - {1'b0, r_opd};

  always_comb begin
    w_acc_next = r_acc;
    if (!w_is_div) begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= OP_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_opd    <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_op     <= op;
      r_sign_a <= src_a[WIDTH-1] & ~op[0];
      r_sign_b <= src_b[WIDTH-1] & ~op[0];
      r_cnt    <= '0;
      if (op[1]) begin
        r_opd <= w_mag_b;
        r_acc <= {{WIDTH{1'b0}}, w_mag_a};
      end else begin
        r_opd <= w_mag_a;
        r_acc <= {{WIDTH{1'b0}}, w_mag_b};
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction applied during FIX. A zero divisor leaves the remainder
  // equal to the dividend magnitude, so the remainder fix-up restores raw src_a.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_prod_fix = r_acc;
    w_quot_fix = r_acc[WIDTH-1:0];
    w_rem_fix  = r_acc[2*WIDTH-1:WIDTH];
    if (w_is_signed && (r_sign_a ^ r_sign_b)) begin
      w_prod_fix = -r_acc;
      w_quot_fix = -r_acc[WIDTH-1:0];
    end
    if (w_is_signed && r_sign_a) w_rem_fix = -r_acc[2*WIDTH-1:WIDTH];
    if (r_opd == '0)             w_quot_fix = '1;
  end

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (w_is_div) begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quot_fix;
    end
  end

  // HI/LO change only on completion or an MT write while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == FIX) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end else if (r_state == IDLE) begin
        if (hi_we) r_hi <= wd;
        if (lo_we) r_lo <= wd;
      end
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
